// File: rtl/i2c_cfg_pkg.sv
// Shared definitions for the I2C register-table sequencer.
package i2c_cfg_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BIT,
    ST_ACK,
    ST_STOP,
    ST_NEXT,
    ST_FIN,
    ST_ERR
  } seq_state_e;

  localparam logic [1:0] Q0 = 2'd0;
  localparam logic [1:0] Q1 = 2'd1;
  localparam logic [1:0] Q2 = 2'd2;
  localparam logic [1:0] Q3 = 2'd3;

  localparam logic [7:0] DEV_ADDR_DEF = 8'h4A;

endpackage

// File: rtl/i2c_phase_div.sv
// Quarter-phase divider: tick every CLK_DIV cycles plus a 2-bit quarter index.
module i2c_phase_div #(
  parameter int CLK_DIV = 250
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  output logic       tick,
  output logic [1:0] qtr
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       qtr_q, qtr_d;

  assign tick = en && (cnt_q == CNT_W'(CLK_DIV - 1));
  assign qtr  = qtr_q;

  always_comb begin
    cnt_d = cnt_q;
    qtr_d = qtr_q;
    if (clr || !en) begin
      cnt_d = '0;
      qtr_d = '0;
    end else if (tick) begin
      cnt_d = '0;
      qtr_d = qtr_q + 2'd1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      qtr_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      qtr_q <= qtr_d;
    end
  end

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Writes every register-table entry to the video decoder as a 3-byte I2C
// write (device address, sub-address, data), retrying NACKed entries.
module i2c_cfg_sequencer
  import i2c_cfg_pkg::*;
#(
  parameter logic [7:0] DEV_ADDR  = DEV_ADDR_DEF,
  parameter int         NUM_REGS  = 20,
  parameter int         IDX_W     = 5,
  parameter int         CLK_DIV   = 250,
  parameter int         MAX_RETRY = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic [IDX_W-1:0] cfg_index,
  input  logic [7:0]       cfg_subaddr,
  input  logic [7:0]       cfg_data,
  output logic             scl_oe,
  output logic             sda_oe,
  input  logic             sda_in,
  output logic             busy,
  output logic             done,
  output logic             error
);

  localparam int RTY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  seq_state_e       state_q, state_d;
  logic             scl_oe_q, scl_oe_d;
  logic             sda_oe_q, sda_oe_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [1:0]       byte_cnt_q, byte_cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shreg_q, shreg_d;
  logic             ok_q, ok_d;
  logic             stop_wait_q, stop_wait_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic             sda_meta_q, sda_sync_q;

  logic       tick;
  logic [1:0] qtr;
  logic       div_clr;

  i2c_phase_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk  (clk),
    .rst  (reset),
    .en   (busy_q),
    .clr  (div_clr),
    .tick (tick),
    .qtr  (qtr)
  );

  assign cfg_index = idx_q;
  assign scl_oe    = scl_oe_q;
  assign sda_oe    = sda_oe_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;

  always_comb begin
    state_d     = state_q;
    scl_oe_d    = scl_oe_q;
    sda_oe_d    = sda_oe_q;
    idx_d       = idx_q;
    retry_d     = retry_q;
    byte_cnt_d  = byte_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shreg_d     = shreg_q;
    ok_d        = ok_q;
    stop_wait_d = stop_wait_q;
    busy_d      = busy_q;
    done_d      = done_q;
    error_d     = error_q;
    div_clr     = 1'b0;

    if (state_q == ST_IDLE) begin
      if (start) begin
        state_d  = ST_START;
        done_d   = 1'b0;
        error_d  = 1'b0;
        idx_d    = '0;
        retry_d  = '0;
        busy_d   = 1'b1;
        scl_oe_d = 1'b0;
        sda_oe_d = 1'b0;
        div_clr  = 1'b1;
      end
    end else if (tick) begin
      case (state_q)
        ST_START: begin
          case (qtr)
            Q0: begin
              scl_oe_d = 1'b0;
              sda_oe_d = 1'b0;
            end
            Q1: sda_oe_d = 1'b1;
            Q2: scl_oe_d = 1'b1;
            default: begin
              shreg_d    = DEV_ADDR;
              byte_cnt_d = 2'd0;
              bit_cnt_d  = 3'd7;
              state_d    = ST_BIT;
            end
          endcase
        end
        ST_BIT: begin
          case (qtr)
            Q0: sda_oe_d = ~shreg_q[7];
            Q1: scl_oe_d = 1'b0;
            Q2: ;
            default: begin
              scl_oe_d = 1'b1;
              if (bit_cnt_q == 3'd0) begin
                state_d = ST_ACK;
              end else begin
                shreg_d   = {shreg_q[6:0], 1'b0};
                bit_cnt_d = bit_cnt_q - 3'd1;
              end
            end
          endcase
        end
        ST_ACK: begin
          case (qtr)
            Q0: sda_oe_d = 1'b0;
            Q1: scl_oe_d = 1'b0;
            Q2: ok_d = ~sda_sync_q;
            default: begin
              scl_oe_d    = 1'b1;
              stop_wait_d = 1'b0;
              if (ok_q && byte_cnt_q != 2'd2) begin
                shreg_d    = (byte_cnt_q == 2'd0) ? cfg_subaddr : cfg_data;
                byte_cnt_d = byte_cnt_q + 2'd1;
                bit_cnt_d  = 3'd7;
                state_d    = ST_BIT;
              end else begin
                state_d = ST_STOP;
              end
            end
          endcase
        end
        // First pass drives the STOP condition, second pass is bus-free time.
        ST_STOP: begin
          case (qtr)
            Q0: if (!stop_wait_q) sda_oe_d = 1'b1;
            Q1: if (!stop_wait_q) scl_oe_d = 1'b0;
            Q2: if (!stop_wait_q) sda_oe_d = 1'b0;
            default: begin
              if (stop_wait_q) state_d = ST_NEXT;
              stop_wait_d = 1'b1;
            end
          endcase
        end
        ST_NEXT: begin
          if (ok_q && idx_q == IDX_W'(NUM_REGS - 1)) begin
            state_d = ST_FIN;
          end else if (ok_q) begin
            idx_d   = idx_q + IDX_W'(1);
            retry_d = '0;
            state_d = ST_START;
            div_clr = 1'b1;
          end else if (retry_q < RTY_W'(MAX_RETRY)) begin
            retry_d = retry_q + RTY_W'(1);
            state_d = ST_START;
            div_clr = 1'b1;
          end else begin
            state_d = ST_ERR;
          end
        end
        ST_FIN: begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        ST_ERR: begin
          error_d = 1'b1;
          busy_d  = 1'b0;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      scl_oe_q    <= 1'b0;
      sda_oe_q    <= 1'b0;
      idx_q       <= '0;
      retry_q     <= '0;
      byte_cnt_q  <= '0;
      bit_cnt_q   <= '0;
      shreg_q     <= '0;
      ok_q        <= 1'b0;
      stop_wait_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      sda_meta_q  <= 1'b1;
      sda_sync_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      scl_oe_q    <= scl_oe_d;
      sda_oe_q    <= sda_oe_d;
      idx_q       <= idx_d;
      retry_q     <= retry_d;
      byte_cnt_q  <= byte_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shreg_q     <= shreg_d;
      ok_q        <= ok_d;
      stop_wait_q <= stop_wait_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      sda_meta_q  <= sda_in;
      sda_sync_q  <= sda_meta_q;
    end
  end

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: open-drain bus with a behavioural slave/monitor
// and a transaction-level model of the expected byte stream and run length.
module tb_i2c_cfg_sequencer;

  localparam int CLK_DIV   = 4;
  localparam int NUM_REGS  = 20;
  localparam int IDX_W     = 5;
  localparam int MAX_RETRY = 3;
  localparam int LIMIT     = 20000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             start = 1'b0;
  logic [IDX_W-1:0] cfg_index;
  logic [7:0]       cfg_subaddr, cfg_data;
  logic             scl_oe, sda_oe, sda_in;
  logic             busy, done, error;

  int n_cmp = 0;
  int n_fail = 0;

  // slave / monitor state (written only by the monitor process)
  logic       slave_pull = 1'b0;
  int         bit_cnt = 0;
  int         byte_no = 0;
  logic [7:0] shv = '0;
  logic [7:0] cur_sub = '0;
  int         nacks_given = 0;
  logic [7:0] obs_q[$];

  // slave configuration (written only by the main process)
  logic       mon_en = 1'b0;
  int         nack_byte = -1;
  logic [7:0] nack_sub = '0;
  int         nack_limit = 0;

  // model outputs
  logic [7:0] exp_q[$];
  int         exp_ticks;
  bit         exp_err;
  int         exp_idx;

  always #5 clk = ~clk;

  assign sda_in = ~(sda_oe | slave_pull);

  i2c_cfg_sequencer #(
    .DEV_ADDR  (8'h4A),
    .NUM_REGS  (NUM_REGS),
    .IDX_W     (IDX_W),
    .CLK_DIV   (CLK_DIV),
    .MAX_RETRY (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_index   (cfg_index),
    .cfg_subaddr (cfg_subaddr),
    .cfg_data    (cfg_data),
    .scl_oe      (scl_oe),
    .sda_oe      (sda_oe),
    .sda_in      (sda_in),
    .busy        (busy),
    .done        (done),
    .error       (error)
  );

  function automatic logic [7:0] rom_sub(input int i);
    return (i == NUM_REGS - 1) ? 8'hFA : 8'(10 + 8 * i);
  endfunction

  function automatic logic [7:0] rom_dat(input int i);
    return (i == NUM_REGS - 1) ? 8'h03 : 8'(1 + i);
  endfunction

  function automatic logic [7:0] byte_of(input int e, input int b);
    return (b == 0) ? 8'h4A : (b == 1) ? rom_sub(e) : rom_dat(e);
  endfunction

  always_comb begin
    cfg_subaddr = rom_sub(int'(cfg_index));
    cfg_data    = rom_dat(int'(cfg_index));
  end

  task automatic chk(input string nm, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, expv);
    end
  endtask

  // Bus monitor and slave. A bit is committed on the SCL fall so that the
  // SCL rise preceding a STOP is not mistaken for a data bit.
  initial begin : monitor
    logic scl_n, sda_n, scl_p, sda_p, pend_bit, pending, hi_valid, in_xfer;
    int   hi_cnt;
    scl_p = 1'b1; sda_p = 1'b1; pending = 1'b0; hi_valid = 1'b0;
    in_xfer = 1'b0; hi_cnt = 0; pend_bit = 1'b0;
    forever begin
      @(negedge clk);
      scl_n = ~scl_oe;
      sda_n = ~(sda_oe | slave_pull);
      if (!mon_en) begin
        slave_pull = 1'b0; bit_cnt = 0; byte_no = 0; nacks_given = 0;
        pending = 1'b0; hi_valid = 1'b0; in_xfer = 1'b0;
        obs_q.delete();
      end else begin
        if (scl_p && scl_n && sda_p != sda_n) begin
          chk("sda_edge_outside_byte", bit_cnt, 0);
          in_xfer  = ~sda_n;
          byte_no  = 0;
          bit_cnt  = 0;
          pending  = 1'b0;
          hi_valid = 1'b0;
        end
        if (!scl_p && scl_n) begin
          hi_cnt   = 1;
          hi_valid = in_xfer;
          pending  = in_xfer;
          pend_bit = sda_n;
        end else if (scl_p && scl_n) begin
          hi_cnt++;
        end
        if (scl_p && !scl_n) begin
          if (hi_valid) chk("scl_high_cycles", hi_cnt, 2 * CLK_DIV);
          hi_valid = 1'b0;
          if (pending) begin
            pending = 1'b0;
            if (bit_cnt < 8) begin
              shv = {shv[6:0], pend_bit};
              bit_cnt++;
              if (bit_cnt == 8) begin
                obs_q.push_back(shv);
                if (byte_no == 1) cur_sub = shv;
                if (byte_no == nack_byte && cur_sub == nack_sub && nacks_given < nack_limit) begin
                  slave_pull = 1'b0;
                  nacks_given++;
                end else begin
                  slave_pull = 1'b1;
                end
              end
            end else begin
              slave_pull = 1'b0;
              bit_cnt = 0;
              byte_no++;
            end
          end
        end
      end
      scl_p = scl_n;
      sda_p = sda_n;
    end
  end

  // Transaction-level model: a full entry is 1 START period, 27 bit periods,
  // STOP + bus-free (2 periods) and one decision tick; a NACK cuts the bytes.
  task automatic build_model(input int nb, input int ne, input int nl);
    int  r, given;
    bit  ok;
    exp_q.delete();
    exp_ticks = 0; exp_err = 1'b0; exp_idx = 0; given = 0;
    for (int e = 0; e < NUM_REGS && !exp_err; e++) begin
      r = 0; ok = 1'b0; exp_idx = e;
      while (!ok && !exp_err) begin
        if (e == ne && given < nl) begin
          given++;
          for (int b = 0; b <= nb; b++) exp_q.push_back(byte_of(e, b));
          exp_ticks += 4 + (nb + 1) * 36 + 8 + 1;
          if (r == MAX_RETRY) exp_err = 1'b1;
          else r++;
        end else begin
          for (int b = 0; b < 3; b++) exp_q.push_back(byte_of(e, b));
          exp_ticks += 4 + 3 * 36 + 8 + 1;
          ok = 1'b1;
        end
      end
    end
    exp_ticks += 1;
  endtask

  task automatic arm_slave(input int nb, input int ne, input int nl);
    nack_byte  = nb;
    nack_sub   = (ne >= 0) ? rom_sub(ne) : 8'h00;
    nack_limit = nl;
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
  endtask

  task automatic run_seq(input bit pulses, output int cycles);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cycles = 0;
    while (busy && cycles < LIMIT) begin
      @(posedge clk); #1;
      cycles++;
      start = (pulses && (cycles == 777 || cycles == 4321)) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    if (busy) chk("run_timeout", 1, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic check_against_model(input string tag, input int cycles);
    chk({tag, "_cycles"}, cycles, exp_ticks * CLK_DIV);
    chk({tag, "_done"}, done, !exp_err);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_index"}, cfg_index, exp_idx);
    chk({tag, "_scl_released"}, scl_oe, 0);
    chk({tag, "_sda_released"}, sda_oe, 0);
    chk({tag, "_nbytes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== exp_q[i]) chk({tag, "_byte"}, obs_q[i], exp_q[i]);
  endtask

  initial begin : main
    int cyc;
    repeat (3) @(negedge clk);
    chk("rst_scl_oe", scl_oe, 0);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_index", cfg_index, 0);

    // all entries ACKed
    build_model(-1, -1, 0);
    arm_slave(-1, -1, 0);
    run_seq(1'b0, cyc);
    check_against_model("full", cyc);
    chk("full_cycles_literal", cyc, 9684);
    chk("full_first_b0", obs_q[0], 8'h4A);
    chk("full_first_b1", obs_q[1], 8'h0A);
    chk("full_first_b2", obs_q[2], 8'h01);
    chk("full_last_b0", obs_q[57], 8'h4A);
    chk("full_last_b1", obs_q[58], 8'hFA);
    chk("full_last_b2", obs_q[59], 8'h03);

    // entry 5 data byte NACKed once
    build_model(2, 5, 1);
    arm_slave(2, 5, 1);
    run_seq(1'b0, cyc);
    check_against_model("retry", cyc);
    chk("retry_nbytes_literal", obs_q.size(), 63);
    chk("retry_cycles_literal", cyc, 10168);
    chk("retry_nacks", nacks_given, 1);

    // entry 5 sub-address NACKed persistently
    build_model(1, 5, 99);
    arm_slave(1, 5, 99);
    run_seq(1'b0, cyc);
    check_against_model("abort", cyc);
    chk("abort_index_literal", cfg_index, 5);
    chk("abort_error_literal", error, 1);
    chk("abort_nbytes_literal", obs_q.size(), 23);
    chk("abort_attempts", nacks_given, 4);

    // reset during bit 3 of the sub-address byte
    arm_slave(-1, -1, 0);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0;
    while (!(byte_no == 1 && bit_cnt == 4) && cyc < 3000) begin
      @(negedge clk); #1;
      cyc++;
    end
    chk("midrst_reached", cyc < 3000, 1);
    chk("midrst_scl_low_before", scl_oe, 1);
    mon_en = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_scl_oe", scl_oe, 0);
    chk("midrst_sda_oe", sda_oe, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_error", error, 0);
    chk("midrst_index", cfg_index, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // restart from index 0 with stray start pulses while busy
    build_model(-1, -1, 0);
    arm_slave(-1, -1, 0);
    run_seq(1'b1, cyc);
    check_against_model("restart", cyc);
    chk("restart_cycles_literal", cyc, 9684);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
